// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit: access-type encodings, FSM states
// and small decode helpers.
package lsu_mem_ctrl_pkg;

    localparam logic [3:0] MEM_LB  = 4'b1000;
    localparam logic [3:0] MEM_LH  = 4'b1001;
    localparam logic [3:0] MEM_LW  = 4'b1010;
    localparam logic [3:0] MEM_LBU = 4'b1011;
    localparam logic [3:0] MEM_LHU = 4'b1111;
    localparam logic [3:0] MEM_SB  = 4'b1100;
    localparam logic [3:0] MEM_SH  = 4'b1101;
    localparam logic [3:0] MEM_SW  = 4'b1110;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_WAIT_ACK,
        LSU_RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_B,
        SZ_H,
        SZ_W
    } access_size_e;

    // LHU shares the 11xx prefix with the stores, so it is excluded explicitly.
    function automatic logic is_store(input logic [3:0] mem_type);
        return (mem_type[3:2] == 2'b11) && (mem_type != MEM_LHU);
    endfunction

    function automatic access_size_e access_size(input logic [3:0] mem_type);
        case (mem_type)
            MEM_LB, MEM_LBU, MEM_SB: return SZ_B;
            MEM_LH, MEM_LHU, MEM_SH: return SZ_H;
            MEM_LW, MEM_SW:          return SZ_W;
            default:                 return SZ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational lane logic: byte enables, store-lane replication, alignment
// check and load extraction with sign/zero extension.
module lsu_mem_ctrl_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [3:0]  mem_type,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic        misaligned,
    output logic [31:0] load_data
);

    logic [31:0] shifted;
    logic        zero_ext;
    logic        store;

    always_comb begin
        byte_en     = 4'b0000;
        store_lanes = 32'h0;
        misaligned  = 1'b0;
        load_data   = 32'h0;
        shifted     = read_word >> {offset, 3'b000};
        zero_ext    = (mem_type == MEM_LBU) || (mem_type == MEM_LHU);
        store       = is_store(mem_type);

        case (access_size(mem_type))
            SZ_B: begin
                byte_en     = 4'b0001 << offset;
                store_lanes = {4{store_data[7:0]}};
                load_data   = zero_ext ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                byte_en     = 4'b0011 << offset;
                misaligned  = offset[0];
                store_lanes = {2{store_data[15:0]}};
                load_data   = zero_ext ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                byte_en     = 4'b1111;
                misaligned  = |offset;
                store_lanes = store_data;
                load_data   = read_word;
            end
            default: ;
        endcase

        // Loads never drive the bus write lanes; stores return no load data.
        if (store) load_data = 32'h0;
        else       store_lanes = 32'h0;
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: accepts one access from execute, runs it on the data-memory
// bus with a timeout, and returns extended load data with fault flags.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        inst_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misaligned,
    output logic              bus_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_err,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e        state, state_next;
    logic [3:0]        cap_type;
    logic [1:0]        cap_off;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       rdata_q;
    logic              mis_q, fault_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;

    logic [3:0]  al_type;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_lanes, al_load;
    logic        al_mis;
    logic        accept, timeout;

    // The aligner sees the live request while idle and the captured one after.
    assign al_type = (state == LSU_IDLE) ? inst_type : cap_type;
    assign al_off  = (state == LSU_IDLE) ? addr[1:0] : cap_off;
    assign accept  = req_valid && (state == LSU_IDLE);
    assign timeout = (cnt == CNT_LAST);

    lsu_mem_ctrl_align u_align (
        .mem_type    (al_type),
        .offset      (al_off),
        .store_data  (wdata),
        .read_word   (mem_rdata),
        .byte_en     (al_be),
        .store_lanes (al_lanes),
        .misaligned  (al_mis),
        .load_data   (al_load)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= LSU_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LSU_IDLE: begin
                if (accept) state_next = (inst_type[3] && !al_mis) ? LSU_WAIT_ACK : LSU_RESP;
            end
            LSU_WAIT_ACK: begin
                if (mem_ack || mem_err || timeout) state_next = LSU_RESP;
            end
            LSU_RESP: state_next = LSU_IDLE;
            default:  state_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_type <= 4'h0;
            cap_off  <= 2'b00;
            cnt      <= '0;
            rdata_q  <= 32'h0;
            mis_q    <= 1'b0;
            fault_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (accept) begin
                        cap_type <= inst_type;
                        cap_off  <= addr[1:0];
                        cnt      <= '0;
                        rdata_q  <= 32'h0;
                        mis_q    <= al_mis;
                        fault_q  <= 1'b0;
                        we_q     <= is_store(inst_type);
                        addr_q   <= {addr[ADDR_W-1:2], 2'b00};
                        be_q     <= al_be;
                        wdata_q  <= al_lanes;
                    end
                end
                LSU_WAIT_ACK: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ack)                 rdata_q <= al_load;
                    else if (mem_err || timeout) fault_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready  = (state == LSU_IDLE);
        mem_req    = (state == LSU_WAIT_ACK);
        done       = (state == LSU_RESP);
        rdata      = done ? rdata_q : 32'h0;
        misaligned = done && mis_q;
        bus_fault  = done && fault_q;
        mem_we     = we_q;
        mem_addr   = addr_q;
        mem_be     = be_q;
        mem_wdata  = wdata_q;
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: vector table of accesses with a bus responder,
// plus hand sequences for reset, abandonment and random loads.
module tb_lsu_mem_ctrl;

    localparam int TIMEOUT = 4;
    localparam int AW      = 32;

    localparam logic [3:0] T_LB  = 4'b1000;
    localparam logic [3:0] T_LH  = 4'b1001;
    localparam logic [3:0] T_LW  = 4'b1010;
    localparam logic [3:0] T_LBU = 4'b1011;
    localparam logic [3:0] T_LHU = 4'b1111;
    localparam logic [3:0] T_SB  = 4'b1100;
    localparam logic [3:0] T_SH  = 4'b1101;
    localparam logic [3:0] T_SW  = 4'b1110;

    // bus response modes
    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_BOTH = 2;
    localparam int M_NONE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    inst_type;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          done;
    logic [31:0]   rdata;
    logic          misaligned;
    logic          bus_fault;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic          mem_err;
    logic [31:0]   mem_rdata;

    int total = 0;
    int bad   = 0;
    logic [33:0] exp_q[$];

    typedef struct {
        logic [3:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          delay;
        int          mode;
        logic        bus;
        logic [3:0]  be;
        logic        we;
        logic [31:0] lanes;
        logic [31:0] exp_rd;
        logic        mis;
        logic        fault;
        int          req_cycles;
    } vec_t;

    vec_t vecs[16];

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .inst_type  (inst_type),
        .addr       (addr),
        .wdata      (wdata),
        .done       (done),
        .rdata      (rdata),
        .misaligned (misaligned),
        .bus_fault  (bus_fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_err    (mem_err),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] typ, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rw, input int dly, input int mode, input logic bus,
                                input logic [3:0] be, input logic we, input logic [31:0] lanes,
                                input logic [31:0] erd, input logic mis, input logic flt, input int rc);
        vec_t v;
        v.typ = typ; v.addr = a; v.wdata = wd; v.rword = rw; v.delay = dly; v.mode = mode;
        v.bus = bus; v.be = be; v.we = we; v.lanes = lanes; v.exp_rd = erd; v.mis = mis;
        v.fault = flt; v.req_cycles = rc;
        return v;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no done");
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("resp", {30'h0, rdata, misaligned, bus_fault}, {30'h0, e});
            end
        end
    end

    task automatic run_access(input vec_t v);
        int req_cyc;
        @(negedge clk);
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1;
        inst_type = v.typ;
        addr      = v.addr;
        wdata     = v.wdata;
        exp_q.push_back({v.exp_rd, v.mis, v.fault});
        @(negedge clk);
        req_valid = 1'b0;
        if (!v.bus) begin
            check("nobus_req", mem_req, 0);
            check("done_lat", done, 1);
        end else begin
            check("mem_req", mem_req, 1);
            check("mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
            check("mem_be", mem_be, v.be);
            check("mem_we", mem_we, v.we);
            check("mem_wdata", mem_wdata, v.lanes);
            req_cyc = 1;
            if (v.mode == M_NONE) begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (mem_req) req_cyc++;
                    else break;
                end
                check("done_lat", done, 1);
            end else begin
                for (int i = 0; i < v.delay; i++) begin
                    @(negedge clk);
                    check("wait_ready", req_ready, 0);
                    check("wait_be", mem_be, v.be);
                    if (mem_req) req_cyc++;
                end
                mem_ack   = (v.mode != M_ERR);
                mem_err   = (v.mode != M_ACK);
                mem_rdata = v.rword;
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_err   = 1'b0;
                mem_rdata = $urandom;
                check("done_lat", done, 1);
                check("req_drop", mem_req, 0);
            end
            check("req_cycles", req_cyc, v.req_cycles);
        end
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; inst_type = 4'h0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;

        //          type   addr          wdata         rword         dly mode    bus be     we lanes         exp_rd        mis flt rc
        vecs[0]  = mk(T_LW,  32'h1000_0008, 32'h0,        32'hDEAD_BEEF, 0, M_ACK,  1, 4'hF, 0, 32'h0,        32'hDEAD_BEEF, 0, 0, 1);
        vecs[1]  = mk(T_LB,  32'h1000_0003, 32'h0,        32'h80FF_0000, 0, M_ACK,  1, 4'h8, 0, 32'h0,        32'hFFFF_FF80, 0, 0, 1);
        vecs[2]  = mk(T_LBU, 32'h1000_0003, 32'h0,        32'h80FF_0000, 0, M_ACK,  1, 4'h8, 0, 32'h0,        32'h0000_0080, 0, 0, 1);
        vecs[3]  = mk(T_SH,  32'h1000_0002, 32'h1234_ABCD, 32'h0,        3, M_ACK,  1, 4'hC, 1, 32'hABCD_ABCD, 32'h0,        0, 0, 4);
        vecs[4]  = mk(T_LW,  32'h1000_0006, 32'h0,        32'h0,         0, M_ACK,  0, 4'h0, 0, 32'h0,        32'h0,         1, 0, 0);
        vecs[5]  = mk(T_LW,  32'h0000_0010, 32'h0,        32'h1234_5678, 0, M_NONE, 1, 4'hF, 0, 32'h0,        32'h0,         0, 1, 4);
        vecs[6]  = mk(T_LH,  32'h0000_0002, 32'h0,        32'h8001_0000, 0, M_BOTH, 1, 4'hC, 0, 32'h0,        32'hFFFF_8001, 0, 0, 1);
        vecs[7]  = mk(T_LHU, 32'h0000_0002, 32'h0,        32'h8001_1234, 1, M_ACK,  1, 4'hC, 0, 32'h0,        32'h0000_8001, 0, 0, 2);
        vecs[8]  = mk(T_SB,  32'h0000_0005, 32'h0000_AA55, 32'h0,        0, M_ACK,  1, 4'h2, 1, 32'h5555_5555, 32'h0,        0, 0, 1);
        vecs[9]  = mk(T_SW,  32'h0000_0008, 32'hCAFE_F00D, 32'h0,        2, M_ACK,  1, 4'hF, 1, 32'hCAFE_F00D, 32'h0,        0, 0, 3);
        vecs[10] = mk(T_LH,  32'h0000_0001, 32'h0,        32'h0,         0, M_ACK,  0, 4'h0, 0, 32'h0,        32'h0,         1, 0, 0);
        vecs[11] = mk(T_SH,  32'h0000_0003, 32'h5555_5555, 32'h0,        0, M_ACK,  0, 4'h0, 0, 32'h0,        32'h0,         1, 0, 0);
        vecs[12] = mk(4'h5,  32'h0000_0003, 32'h0,        32'h0,         0, M_ACK,  0, 4'h0, 0, 32'h0,        32'h0,         0, 0, 0);
        vecs[13] = mk(T_LH,  32'h0000_0000, 32'h0,        32'hFFFF_FFFF, 1, M_ERR,  1, 4'h3, 0, 32'h0,        32'h0,         0, 1, 2);
        vecs[14] = mk(T_LB,  32'h0000_0001, 32'h0,        32'h0000_7F00, 0, M_ACK,  1, 4'h2, 0, 32'h0,        32'h0000_007F, 0, 0, 1);
        vecs[15] = mk(T_SW,  32'h0000_0002, 32'h1111_2222, 32'h0,        0, M_ACK,  0, 4'h0, 0, 32'h0,        32'h0,         1, 0, 0);

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_outs", {done, misaligned, bus_fault, mem_req, mem_we, mem_be}, 0);
        check("rst_data", {rdata, mem_wdata}, 0);
        check("rst_addr", mem_addr, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_access(vecs[i]);

        // Reset mid-access abandons the transfer; a late ack must be ignored.
        @(negedge clk);
        req_valid = 1'b1; inst_type = T_LW; addr = 32'h0000_0040;
        @(negedge clk);
        req_valid = 1'b0;
        check("abandon_req", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abandon_drop", mem_req, 0);
        check("abandon_ready", req_ready, 1);
        check("abandon_addr", mem_addr, 0);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_done", done, 0);
        check("late_ack_req", mem_req, 0);
        run_access(mk(T_SB, 32'h0000_0043, 32'h0000_007E, 32'h0, 0, M_ACK, 1, 4'h8, 1,
                      32'h7E7E_7E7E, 32'h0, 0, 0, 1));

        // Random aligned LW / LBU loads against a small extraction model
        for (int i = 0; i < 8; i++) begin
            logic [31:0] rw, a, exp;
            logic [1:0]  off;
            int          dly;
            rw  = $urandom;
            dly = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                a = {$urandom_range(0, 255), 2'b00};
                run_access(mk(T_LW, a, 32'h0, rw, dly, M_ACK, 1, 4'hF, 0, 32'h0, rw, 0, 0, dly + 1));
            end else begin
                off = 2'($urandom_range(0, 3));
                a   = {22'h0, 8'($urandom_range(0, 255)), off};
                exp = (rw >> (8 * off)) & 32'hFF;
                run_access(mk(T_LBU, a, 32'h0, rw, dly, M_ACK, 1, 4'b0001 << off, 0, 32'h0, exp, 0, 0, dly + 1));
            end
        end

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit that consumes the 4-bit memory access type produced by instruction decode, together with the ALU-computed address and the rs2 store data.
- Generates a word-aligned request on the data-memory bus with byte enables and lane-replicated write data.
- Waits for an acknowledge, then returns a sign- or zero-extended load result to writeback.
- Flags misaligned accesses and bus faults for the CSR/trap logic.
- Sits between the execute stage and the data-memory port.

Parameters:
TIMEOUT_CYCLES, 16, cycles in WAIT_ACK before a bus fault is declared; minimum 1.
ADDR_W, 32, byte-address width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  execute presents an access this cycle
req_ready  out  1  unit can accept (high only in IDLE)
inst_type  in  4  access type: 1000 LB, 1001 LH, 1010 LW, 1011 LBU, 1111 LHU, 1100 SB, 1101 SH, 1110 SW, 0xxx no access
addr  in  ADDR_W  byte address from ALU
wdata  in  32  rs2 store data
done  out  1  one-cycle completion pulse
rdata  out  32  extended load data, valid with done
misaligned  out  1  valid with done; access not naturally aligned
bus_fault  out  1  valid with done; mem_err or timeout
mem_req  out  1  bus request, held until ack/err/timeout
mem_we  out  1  1 = store
mem_addr  out  ADDR_W  word address (addr with [1:0] = 00)
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  access complete; mem_rdata valid for loads
mem_err  in  1  access terminated with error
mem_rdata  in  32  read word

Behaviour:
- States: IDLE, WAIT_ACK, RESP.
- Reset (at clk edge with rst=1): state=IDLE, timeout counter=0, captured type/offset=0. Reset forces these outputs to 0: done, rdata, misaligned, bus_fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata. req_ready is 1 in IDLE, including immediately after reset.
- Accept: handshake is req_valid & req_ready. On it, register inst_type, addr[1:0], mem_addr, mem_be, mem_wdata and mem_we.
- Alignment: H types (LH, LHU, SH) require addr[0]=0. W types (LW, SW) require addr[1:0]=00. B types are always aligned.
- Misaligned or 0xxx access: no bus activity; go to RESP. For misaligned, misaligned=1. For 0xxx, all flags are 0 and rdata=0.
- Aligned 1xxx access: go to WAIT_ACK. mem_req=1 from the cycle after accept; mem_addr, mem_be, mem_we and mem_wdata are stable while mem_req=1.
- Byte enables: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
- Store data: SB replicates wdata[7:0] into all 4 lanes; SH replicates wdata[15:0] into both halves; SW passes wdata unchanged.
- WAIT_ACK, each cycle: the counter increments.
  - mem_ack: drop mem_req next edge; go to RESP; capture the extended load data.
  - mem_err (and not mem_ack): go to RESP with bus_fault=1.
  - Neither, and counter = TIMEOUT_CYCLES-1: go to RESP with bus_fault=1.
  - Priority: ack > err > timeout.
- Load extraction: select the lane with the captured addr[1:0]. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend. Stores return rdata=0. On any fault, rdata=0.
- RESP: done=1 for exactly one cycle, then IDLE. req_ready=0 in WAIT_ACK and RESP, so a new request is accepted the cycle after done at the earliest.
- Latency, aligned access: accept at cycle 0, mem_req high at cycle 1. Ack in cycle k gives done at cycle k+1. Zero-wait ack gives done at cycle 2.
- Latency, misaligned or no-op: done at cycle 1.
- Outside RESP, done, misaligned and bus_fault are all 0.
- req_valid while busy is ignored; execute must hold it (stall).
- rst asserted mid-access abandons the transfer (mem_req low after that edge) and produces no done. A late mem_ack arriving in IDLE is ignored.

Decomposition:
- Common package gets:
  - mem-type constants MEM_LB=4'b1000, MEM_LH=4'b1001, MEM_LW=4'b1010, MEM_LBU=4'b1011, MEM_LHU=4'b1111, MEM_SB=4'b1100, MEM_SH=4'b1101, MEM_SW=4'b1110;
  - enum lsu_state_e {LSU_IDLE, LSU_WAIT_ACK, LSU_RESP};
  - function is_store(type) = type[3:2]==2'b11 && type!=MEM_LHU.
- One combinational sub-module, lsu_align, producing byte enables, replicated store data, misaligned flag, and load extraction/extension. It is reusable for an instruction-side or DMA port.

Test Plan:
- LW, addr=0x1000_0008, mem_ack in cycle 1, mem_rdata=0xDEAD_BEEF -> mem_addr=0x1000_0008, mem_be=1111, done at cycle 2, rdata=0xDEAD_BEEF, flags 0.
- LB and LBU, addr=0x...03, mem_rdata=0x80FF_0000 -> mem_be=1000; LB rdata=0xFFFF_FF80, LBU rdata=0x0000_0080.
- SH, addr=0x...02, wdata=0x1234_ABCD, ack after 3 wait cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_req held 4 cycles, done one cycle after ack.
- LW, addr=0x...06 -> mem_req never asserted, done at cycle 1, misaligned=1, rdata=0.
- Load with no ack, TIMEOUT_CYCLES=4 -> mem_req high exactly 4 cycles, done with bus_fault=1. Separately, mem_err and mem_ack in the same cycle -> bus_fault=0.
- rst pulse in WAIT_ACK, then mem_ack 2 cycles later -> mem_req=0 after the reset edge, no done, req_ready=1. A new SB request then completes normally.
